// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES tables, state type and permutation helpers shared by the encrypt and decrypt datapaths
// Purpose: FIPS 46-3 permutation tables, S-boxes and key shift schedule.
// Ports: none (package). Bit convention everywhere: DES bit n lives at vector index (width - n).
package des_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} des_state_e;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int IPI_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                  38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                  36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                  34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Each S-box is 4 rows of 16 nibbles, row 0 column 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] ip_inv(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IPI_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    // Parity bits (DES bits 8,16,..,64) are simply never selected.
    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    // Row comes from the outer bits, column from the middle four.
    function automatic logic [3:0] sbox(input int n, input logic [5:0] b);
        logic [255:0] t;
        logic [5:0]   idx;
        t   = SBOX[n];
        idx = {b[5], b[0], b[4:1]};
        return t[8'(255 - 4 * idx) -: 4];
    endfunction

endpackage

// File: rtl/des_encrypt_iter_if.sv
// rtl/des_encrypt_iter_if.sv - job input and ciphertext output handshakes of the DES encryptor
// Purpose: bundles the in_*/out_* valid/ready channels and the busy flag.
// Ports: master = job producer / ciphertext consumer, slave = encryptor.
interface des_encrypt_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    modport master (output in_valid, in_data, in_key, out_ready,
                    input  in_ready, out_valid, out_data, busy);
    modport slave  (input  in_valid, in_data, in_key, out_ready,
                    output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/des_round_f.sv
// rtl/des_round_f.sv - combinational DES round function f(R, K)
// Purpose: E-expansion, key mix, S-box substitution and P permutation.
// Ports: r_i (32) right half, k_i (48) round key, f_o (32) result.
module des_round_f
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] x;
    logic [31:0] s;

    always_comb begin
        x = e_exp(r_i) ^ k_i;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[5'(31 - 4 * i) -: 4] = sbox(i, x[6'(47 - 6 * i) -: 6]);
        end
        f_o = p_perm(s);
    end

endmodule

// File: rtl/des_encrypt_iter.sv
// rtl/des_encrypt_iter.sv - iterative DES encryptor, ROUNDS_PER_CYCLE Feistel rounds per clock
// Purpose: accepts plaintext+key, runs 16 rounds, presents ciphertext until consumed.
// Ports: clk, rst_n (async active-low), bus (slave: in_valid/in_ready/in_data/in_key,
//        out_valid/out_ready/out_data, busy).
module des_encrypt_iter
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    des_encrypt_iter_if.slave  bus
);

    localparam int RPC = ROUNDS_PER_CYCLE;

    generate
        if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
            $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    des_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, dk_q, dk_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;

    // Unrolled round chain: index 0 is the registered state, index RPC the result.
    logic [31:0] l_s  [RPC+1];
    logic [31:0] r_s  [RPC+1];
    logic [27:0] c_s  [RPC+1];
    logic [27:0] dk_s [RPC+1];
    logic [47:0] k_s  [RPC];
    logic [31:0] f_s  [RPC];

    assign l_s[0]  = l_q;
    assign r_s[0]  = r_q;
    assign c_s[0]  = c_q;
    assign dk_s[0] = dk_q;

    generate
        for (genvar g = 0; g < RPC; g++) begin : g_round
            logic [3:0] ridx;
            logic       one;
            assign ridx = cnt_q[3:0] + 4'(g);
            assign one  = (SHIFTS[ridx] == 1);
            assign c_s[g+1]  = one ? {c_s[g][26:0], c_s[g][27]}     : {c_s[g][25:0], c_s[g][27:26]};
            assign dk_s[g+1] = one ? {dk_s[g][26:0], dk_s[g][27]}   : {dk_s[g][25:0], dk_s[g][27:26]};
            assign k_s[g]    = pc2({c_s[g+1], dk_s[g+1]});
            des_round_f u_round_f (.r_i(r_s[g]), .k_i(k_s[g]), .f_o(f_s[g]));
            assign l_s[g+1] = r_s[g];
            assign r_s[g+1] = l_s[g] ^ f_s[g];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        c_d         = c_q;
        dk_d        = dk_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    {l_d, r_d}  = ip(bus.in_data);
                    {c_d, dk_d} = pc1(bus.in_key);
                    cnt_d       = '0;
                    state_d     = ST_ROUND;
                end
            end
            ST_ROUND: begin
                l_d   = l_s[RPC];
                r_d   = r_s[RPC];
                c_d   = c_s[RPC];
                dk_d  = dk_s[RPC];
                cnt_d = cnt_q + 5'(RPC);
                if (cnt_d == 5'd16) begin
                    // Final swap: the output permutation takes R16 as the left half.
                    out_data_d  = ip_inv({r_s[RPC], l_s[RPC]});
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            dk_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            c_q         <= c_d;
            dk_q        <= dk_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_des_encrypt_iter.sv
// tb/tb_des_encrypt_iter.sv - known-answer, backpressure, interference and reset-abort checks for des_encrypt_iter
module tb_des_encrypt_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;

    always #5 clk = ~clk;

    des_encrypt_iter_if bus1 ();
    des_encrypt_iter_if bus4 ();
    des_encrypt_iter_if bus16 ();

    assign bus1.in_valid   = in_valid;
    assign bus1.in_data    = in_data;
    assign bus1.in_key     = in_key;
    assign bus1.out_ready  = out_ready;
    assign bus4.in_valid   = in_valid;
    assign bus4.in_data    = in_data;
    assign bus4.in_key     = in_key;
    assign bus4.out_ready  = out_ready;
    assign bus16.in_valid  = in_valid;
    assign bus16.in_data   = in_data;
    assign bus16.in_key    = in_key;
    assign bus16.out_ready = out_ready;

    des_encrypt_iter #(.ROUNDS_PER_CYCLE(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    des_encrypt_iter #(.ROUNDS_PER_CYCLE(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    des_encrypt_iter #(.ROUNDS_PER_CYCLE(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    logic [2:0]  ov, ir, bz;
    logic [63:0] od [3];
    assign ov = {bus16.out_valid, bus4.out_valid, bus1.out_valid};
    assign ir = {bus16.in_ready,  bus4.in_ready,  bus1.in_ready};
    assign bz = {bus16.busy,      bus4.busy,      bus1.busy};
    assign od[0] = bus1.out_data;
    assign od[1] = bus4.out_data;
    assign od[2] = bus16.out_data;

    localparam int LAT [3] = '{16, 4, 1};
    localparam int RPCS [3] = '{1, 4, 16};

    typedef struct {
        logic [63:0] key;
        logic [63:0] pt;
        logic [63:0] ct;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input vec_t v, input string name);
        int          lat [3];
        int          wid [3];
        logic [63:0] got [3];
        chk({name, " idle before"}, 64'(ir), 64'(3'b111));
        for (int k = 0; k < 3; k++) begin
            lat[k] = -1;
            wid[k] = 0;
            got[k] = '0;
        end
        in_key   = v.key;
        in_data  = v.pt;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_key   = {$urandom, $urandom};
        for (int n = 1; n <= 24; n++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                if (ov[k]) begin
                    if (lat[k] < 0) begin
                        lat[k] = n;
                        got[k] = od[k];
                    end
                    wid[k]++;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s rpc%0d data", name, RPCS[k]), got[k], v.ct);
            chk($sformatf("%s rpc%0d latency", name, RPCS[k]), 64'(lat[k]), 64'(LAT[k]));
            chk($sformatf("%s rpc%0d width", name, RPCS[k]), 64'(wid[k]), 64'd1);
        end
    endtask

    task automatic wait_all_valid(input string name);
        int n = 0;
        while (ov != 3'b111 && n < 40) begin
            step();
            n++;
        end
        chk({name, " all valid"}, 64'(ov), 64'(3'b111));
    endtask

    initial begin
        vec_t vecs [5];
        int   errs;
        vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405};
        vecs[1] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000};
        vecs[2] = '{64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7};
        vecs[3] = '{64'h0101010101010101, 64'h0000000000000000, 64'h8CA64DE9C1B123A7};
        vecs[4] = '{64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset rpc%0d out_valid", RPCS[k]), 64'(ov[k]), 64'd0);
            chk($sformatf("reset rpc%0d out_data", RPCS[k]), od[k], 64'd0);
            chk($sformatf("reset rpc%0d busy", RPCS[k]), 64'(bz[k]), 64'd0);
        end
        rst_n = 1'b1;
        step();
        chk("after reset in_ready", 64'(ir), 64'(3'b111));

        for (int i = 0; i < 5; i++) run_job(vecs[i], $sformatf("kat%0d", i));

        // Backpressure: ciphertext held while out_ready is low.
        out_ready = 1'b0;
        in_key    = vecs[0].key;
        in_data   = vecs[0].pt;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        wait_all_valid("bp");
        errs = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (ov != 3'b111 || ir != 3'b000 || bz != 3'b111) errs++;
            for (int k = 0; k < 3; k++) if (od[k] !== vecs[0].ct) errs++;
        end
        chk("bp hold", 64'(errs), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp release in_ready", 64'(ir), 64'(3'b111));
        chk("bp release out_valid", 64'(ov), 64'd0);
        run_job(vecs[1], "bp second");

        // Interference: garbage jobs offered while busy, then in_valid overlapping the drain.
        out_ready = 1'b0;
        in_key    = vecs[0].key;
        in_data   = vecs[0].pt;
        in_valid  = 1'b1;
        step();
        for (int n = 0; n < 15; n++) begin
            in_data = {$urandom, $urandom};
            in_key  = {$urandom, $urandom};
            step();
        end
        wait_all_valid("intf");
        for (int k = 0; k < 3; k++)
            chk($sformatf("intf rpc%0d data", RPCS[k]), od[k], vecs[0].ct);
        out_ready = 1'b1;
        in_data   = {$urandom, $urandom};
        step();
        in_valid = 1'b0;
        chk("intf drain in_ready", 64'(ir), 64'(3'b111));
        chk("intf drain out_valid", 64'(ov), 64'd0);
        step();
        chk("intf no extra job", 64'(bz), 64'd0);

        // Reset abort in round 7 of the single-round instance.
        out_ready = 1'b0;
        in_key    = vecs[0].key;
        in_data   = vecs[0].pt;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        chk("abort busy before", 64'(bz), 64'(3'b111));
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(ov), 64'd0);
        chk("abort busy", 64'(bz), 64'd0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("abort rpc%0d out_data", RPCS[k]), od[k], 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("abort in_ready", 64'(ir), 64'(3'b111));
        out_ready = 1'b1;
        run_job(vecs[1], "after abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/des_encrypt_iter.md
Name: des_encrypt_iter

Overview:
- Iterative, clocked DES encryptor: the forward (encrypt) direction of the team's DES datapath.
- Accepts one 64-bit plaintext block and one 64-bit key through a valid/ready handshake.
- Runs the 16 Feistel rounds over multiple clock cycles and presents the 64-bit ciphertext through a valid/ready output handshake.
- Output must be bit-exact with FIPS 46-3 so the existing decrypt path recovers the plaintext.

Parameters:
- ROUNDS_PER_CYCLE, 1, Feistel rounds per clock; legal values 1, 2, 4, 8, 16; any other value is a compile-time error.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset, synchronous deassertion handled externally
- in_valid  input  1  plaintext/key present
- in_ready  output  1  block can accept a new job
- in_data  input  64  plaintext, bit 63 = DES bit 1
- in_key  input  64  key incl. parity bits, bit 63 = DES bit 1
- out_valid  output  1  ciphertext present
- out_ready  input  1  consumer accepts ciphertext
- out_data  output  64  ciphertext, bit 63 = DES bit 1
- busy  output  1  high in ROUND or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, round counter = 0, L/R/C/D registers = 0, out_data = 0, out_valid = 0, busy = 0. in_ready = 1 once reset is released.
- Reset mid-operation aborts the job. No partial result is ever presented.
- FSM states: IDLE, ROUND, DONE.
- in_ready is a combinational decode of (state == IDLE) only. It never depends on in_valid.
- IDLE, handshake (in_valid && in_ready) at edge A:
  - {L,R} <= IP(in_data).
  - {C,D} <= PC-1(in_key). The 8 parity bits are ignored and never checked.
  - round counter <= 0; next state ROUND.
- ROUND, each edge:
  - Apply ROUNDS_PER_CYCLE rounds back-to-back combinationally.
  - Round i (1..16): rotate C and D left by 1 for i in {1,2,9,16}, else by 2. K_i = PC-2(C,D). L' = R, R' = L xor f(R, K_i).
  - counter += ROUNDS_PER_CYCLE.
- On the edge that completes round 16:
  - out_data <= IP^-1({R16, L16}) (halves swapped).
  - out_valid <= 1; next state DONE.
- Latency: out_valid first high in the cycle after edge A + 16/ROUNDS_PER_CYCLE (16 cycles after the accept edge at default).
- DONE: out_valid and out_data held stable while out_ready is low, for any number of cycles.
  - On out_valid && out_ready: out_valid <= 0, state <= IDLE.
  - out_data keeps its last value; it is don't-care when out_valid = 0.
- Throughput at default: one block per 18 cycles with out_ready tied high.
- in_valid asserted in ROUND/DONE is ignored; in_data and in_key are not sampled and need not be stable then.
- in_data/in_key are only sampled at the handshake edge; later changes have no effect on the job.
- out_ready asserted in IDLE/ROUND has no effect.
- Simultaneous in_valid and out_ready in DONE: the output completes that cycle. The new input is accepted no earlier than the next cycle, in IDLE.
- Counter width is 5 bits. It must not wrap inside a job; reaching 16 ends the job.

Decomposition:
- Shared package des_pkg holds:
  - the state enum typedef;
  - IP, IP^-1, E, P, PC-1, PC-2 permutation tables;
  - S-box tables S1..S8;
  - the 16-entry shift schedule.
- The existing decrypt datapath reuses the same package.
- One combinational sub-module, des_round_f: inputs R (32) and K (48), output f (32). It implements E-expansion, xor, S-boxes and P.
- Instantiate des_round_f ROUNDS_PER_CYCLE times in a generate loop.
- Key schedule and FSM stay in des_encrypt_iter.

Test Plan:
- Known-answer vector 1: key 133457799BBCDFF1, pt 0123456789ABCDEF, out_ready = 1 -> out_valid exactly 16 cycles after accept edge, out_data = 85E813540F0AB405, one cycle wide.
- Known-answer vector 2: key 0E329232EA6D0D73, pt 8787878787878787 -> out_data = 0000000000000000.
- Known-answer vector 3: key 0000000000000000, pt 0000000000000000 -> out_data = 8CA64DE9C1B123A7. Repeat with key 0101010101010101 (parity-only bits): same result.
- Backpressure: vector 1 with out_ready low for 10 cycles after out_valid -> out_valid/out_data stable throughout, in_ready = 0. Raise out_ready -> in_ready = 1 next cycle. A second block then completes correctly.
- Interference: change in_data/in_key and pulse in_valid every cycle during ROUND -> result still 85E813540F0AB405 and no extra job accepted.
- Reset abort: assert rst_n low at round 7 of vector 1 -> all outputs 0 immediately, in_ready = 1 after release. The next job (vector 2) is correct.
- Repeat all vectors with ROUNDS_PER_CYCLE = 4 (latency 4) and 16 (latency 1) -> identical ciphertexts.
- Round trip: feed each ciphertext to the team's DES decrypt block -> original plaintext returned.
